// File: rtl/cpu_pkg.sv
// Shared types and default widths for the memory access sequencer.
// mem_seq_state_t encodes the IDLE -> REQ -> DONE handshake walk.
package cpu_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_REQ,
    MS_DONE
  } mem_seq_state_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// REQ-phase wait counter: clears on REQ entry, counts un-acked REQ cycles.
// expired_o fires combinationally in the REQ cycle that makes the count reach TMO_MAX.
module mem_timeout_ctr #(
  parameter int TMO_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);
  localparam int CW = $clog2(TMO_MAX + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = inc_i && (cnt_q == CW'(TMO_MAX - 1));
endmodule

// File: rtl/mem_access_sequencer.sv
// Turns controller fetch/load/store accesses into mem_req/mem_ack transactions and stalls via clk_en.
// Optional REQ timeout abort is compiled in with `define MEM_TIMEOUT_EN.
module mem_access_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TMO_MAX = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_rd,
  input  logic              acc_wr,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              clk_en,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_vld,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              acc_err
);
  mem_seq_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              tmo_expired;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .TMO_MAX(TMO_MAX)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clear_i  ((state_q == MS_IDLE) && (acc_rd || acc_wr)),
    .inc_i    ((state_q == MS_REQ) && !mem_ack),
    .expired_o(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MS_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    clk_en  = 1'b1;
    mem_req = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (acc_rd || acc_wr) begin
          clk_en  = 1'b0;
          addr_d  = acc_addr;
          wdata_d = acc_wdata;
          // A simultaneous rd+wr is treated as a write and flagged.
          we_d    = acc_wr;
          if (acc_rd && acc_wr) err_d = 1'b1;
          state_d = MS_REQ;
        end
      end
      MS_REQ: begin
        mem_req = 1'b1;
        clk_en  = 1'b0;
        if (mem_ack) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = MS_DONE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = MS_DONE;
        end
      end
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  assign rdata     = rdata_q;
  assign rdata_vld = (state_q == MS_DONE) && !we_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign acc_err   = err_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer; timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_mem_access_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acc_rd = 1'b0, acc_wr = 1'b0;
  logic [31:0] acc_addr = '0, acc_wdata = '0;
  logic        clk_en, rdata_vld, mem_req, mem_we, acc_err;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
  mem_access_sequencer #(.ADDR_W(32), .DATA_W(32), .TMO_MAX(4)) dut (
`else
  mem_access_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
`endif
    .clk(clk), .rst(rst), .acc_rd(acc_rd), .acc_wr(acc_wr),
    .acc_addr(acc_addr), .acc_wdata(acc_wdata), .clk_en(clk_en),
    .rdata(rdata), .rdata_vld(rdata_vld), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .acc_err(acc_err)
  );

  // Starts and ends just after a rising edge with the DUT in IDLE; ack arrives k cycles into REQ.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int k, input logic [31:0] rdat,
                            output int low, output bit req_ok, output bit hold_ok,
                            output logic done_ce, output logic done_vld,
                            output logic [31:0] done_rdata);
    low = 0; req_ok = 1; hold_ok = 1;
    acc_rd = rd; acc_wr = wr; acc_addr = a; acc_wdata = wd;
    #1;
    if (!clk_en) low++;
    @(posedge clk); #1;
    for (int i = 0; i <= k; i++) begin
      mem_ack   = (i == k);
      mem_rdata = (i == k) ? rdat : 32'h0BAD_0000;
      #1;
      if (mem_req !== 1'b1) req_ok = 0;
      if (mem_addr !== a || mem_we !== wr || (wr && mem_wdata !== wd)) hold_ok = 0;
      if (!clk_en) low++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; acc_rd = 1'b0; acc_wr = 1'b0;
    #1;
    done_ce = clk_en; done_vld = rdata_vld; done_rdata = rdata;
    if (mem_req !== 1'b0) req_ok = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (clk_en !== 1'b1) begin n_bad++; $display("FAIL reset_clk_en got %b want 1", clk_en); end
    n_cmp++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_req_we got %b%b want 00", mem_req, mem_we); end
    n_cmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_addr_wdata got %h %h want 0 0", mem_addr, mem_wdata); end
    n_cmp++; if (rdata !== 32'h0 || rdata_vld !== 1'b0 || acc_err !== 1'b0) begin n_bad++; $display("FAIL reset_rdata_vld_err got %h %b %b want 0 0 0", rdata, rdata_vld, acc_err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    int low; bit rq, hd; logic ce, vld; logic [31:0] rd;
    run_access(1'b1, 1'b0, 32'h0, 32'h0, 0, 32'h2008_0005, low, rq, hd, ce, vld, rd);
    n_cmp++; if (low !== 2) begin n_bad++; $display("FAIL fetch_stall got %0d want 2", low); end
    n_cmp++; if (!rq) begin n_bad++; $display("FAIL fetch_req got bad want req high only in REQ"); end
    n_cmp++; if (ce !== 1'b1 || vld !== 1'b1) begin n_bad++; $display("FAIL fetch_done got ce=%b vld=%b want 1 1", ce, vld); end
    n_cmp++; if (rd !== 32'h2008_0005) begin n_bad++; $display("FAIL fetch_rdata got %h want 20080005", rd); end
    n_cmp++; if (rdata_vld !== 1'b0 || clk_en !== 1'b1) begin n_bad++; $display("FAIL fetch_idle got vld=%b ce=%b want 0 1", rdata_vld, clk_en); end
  endtask

  task automatic test_load_wait();
    int low; bit rq, hd; logic ce, vld; logic [31:0] rd;
    run_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 3, 32'h1234_5678, low, rq, hd, ce, vld, rd);
    n_cmp++; if (low !== 5) begin n_bad++; $display("FAIL load_stall got %0d want 5", low); end
    n_cmp++; if (!hd || !rq) begin n_bad++; $display("FAIL load_addr_hold got hold=%b req=%b want 1 1", hd, rq); end
    n_cmp++; if (rd !== 32'h1234_5678 || vld !== 1'b1 || ce !== 1'b1) begin n_bad++; $display("FAIL load_rdata got %h vld=%b ce=%b want 12345678 1 1", rd, vld, ce); end
  endtask

  task automatic test_store();
    int low; bit rq, hd; logic ce, vld; logic [31:0] rd;
    run_access(1'b0, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, low, rq, hd, ce, vld, rd);
    n_cmp++; if (!hd) begin n_bad++; $display("FAIL store_we_wdata got hold=0 want mem_we=1 wdata=deadbeef"); end
    n_cmp++; if (rd !== 32'h1234_5678 || vld !== 1'b0) begin n_bad++; $display("FAIL store_rdata got %h vld=%b want 12345678 0", rd, vld); end
    n_cmp++; if (low !== 2 || acc_err !== 1'b0) begin n_bad++; $display("FAIL store_stall_err got %0d err=%b want 2 0", low, acc_err); end
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (clk_en !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL stray_idle got ce=%b req=%b want 1 0", clk_en, mem_req); end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_cmp++; if (rdata !== 32'h1234_5678 || rdata_vld !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL stray_rdata got %h vld=%b req=%b want 12345678 0 0", rdata, rdata_vld, mem_req); end
  endtask

  task automatic test_rd_wr_conflict();
    int low; bit rq, hd; logic ce, vld; logic [31:0] rd;
    run_access(1'b1, 1'b1, 32'h0000_0090, 32'h0000_0055, 1, 32'hFFFF_FFFF, low, rq, hd, ce, vld, rd);
    n_cmp++; if (!hd || low !== 3) begin n_bad++; $display("FAIL conflict_write got hold=%b stall=%0d want 1 3", hd, low); end
    n_cmp++; if (acc_err !== 1'b1 || vld !== 1'b0) begin n_bad++; $display("FAIL conflict_err got err=%b vld=%b want 1 0", acc_err, vld); end
    run_access(1'b1, 1'b0, 32'h0000_00A0, 32'h0, 0, 32'hCAFE_0001, low, rq, hd, ce, vld, rd);
    n_cmp++; if (acc_err !== 1'b1 || rd !== 32'hCAFE_0001) begin n_bad++; $display("FAIL conflict_sticky got err=%b rdata=%h want 1 cafe0001", acc_err, rd); end
  endtask

  task automatic test_reset_mid();
    acc_rd = 1'b1; acc_addr = 32'h0000_0100;
    @(posedge clk); #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_inreq got %b want 1", mem_req); end
    rst = 1'b1; acc_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (mem_req !== 1'b0 || clk_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_drop got req=%b ce=%b want 0 1", mem_req, clk_en); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_cmp++; if (rdata !== 32'h0 || rdata_vld !== 1'b0 || mem_req !== 1'b0 || clk_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_late_ack got rdata=%h vld=%b req=%b ce=%b want 0 0 0 1", rdata, rdata_vld, mem_req, clk_en); end
    n_cmp++; if (acc_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err got %b want 0", acc_err); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int low, n; bit rq, hd; logic ce, vld; logic [31:0] rd;
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h1111_2222, low, rq, hd, ce, vld, rd);
    acc_rd = 1'b1; acc_addr = 32'h0000_0200;
    @(posedge clk); #1;
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    acc_rd = 1'b0;
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL timeout_cycles got %0d want 4", n); end
    n_cmp++; if (clk_en !== 1'b1 || acc_err !== 1'b1 || rdata !== 32'h0) begin n_bad++; $display("FAIL timeout_done got ce=%b err=%b rdata=%h want 1 1 0", clk_en, acc_err, rdata); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_load_wait();
    test_store();
    test_stray_ack();
    test_rd_wr_conflict();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
